// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state codes, command codes and drain default for the pipeline controller.
package pipeline_pkg;
    localparam int DRAIN_CYC_DEF = 3;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;
    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_STOP = 2'd3
    } cmd_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: debug command handshake, halt detect and pipeline control outputs.
interface pipeline_ctrl_if #(
    parameter int CNT_SZ = 32,
    parameter int CMD_SZ = 2
);
    logic [CMD_SZ-1:0] i_cmd;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_halt_D;
    logic              o_pipe_en;
    logic              o_pc_en;
    logic              o_halted;
    logic [CNT_SZ-1:0] o_cycle_count;
    logic [2:0]        o_state;
    modport master (
        output i_cmd, i_cmd_valid, i_halt_D,
        input  o_cmd_ready, o_pipe_en, o_pc_en, o_halted, o_cycle_count, o_state
    );
    modport slave (
        input  i_cmd, i_cmd_valid, i_halt_D,
        output o_cmd_ready, o_pipe_en, o_pc_en, o_halted, o_cycle_count, o_state
    );
endinterface

// File: rtl/cycle_counter.sv
// cycle_counter: wrapping enable counter with synchronous active-low reset.
module cycle_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    always_ff @(posedge i_clk) begin
        if (!i_reset) o_count <= '0;
        else if (i_en) o_count <= o_count + W'(1);
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: debug-driven run/step/stop controller that drains the pipeline on HALT.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_SZ    = 32,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int CMD_SZ    = 2
) (
    input logic           i_clk,
    input logic           i_reset,
    pipeline_ctrl_if.slave bus
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t          state, state_nx;
    logic [DW-1:0]   drain_cnt;
    logic            ready, accept, pipe_en, pc_en, drain_last;
    logic [CNT_SZ-1:0] count;

    assign ready      = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);
    assign accept     = bus.i_cmd_valid && ready;
    assign drain_last = drain_cnt == DW'(DRAIN_CYC - 1);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

    // HALT in ID takes priority over any command arriving in the same cycle
    always_comb begin
        state_nx = state;
        pipe_en  = 1'b0;
        pc_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx = (accept && bus.i_cmd == CMD_SZ'(CMD_RUN))  ? ST_RUN  :
                           (accept && bus.i_cmd == CMD_SZ'(CMD_STEP)) ? ST_STEP : ST_IDLE;
            end
            ST_RUN: begin
                pipe_en  = 1'b1;
                pc_en    = !bus.i_halt_D;
                state_nx = bus.i_halt_D ? ST_DRAIN :
                           (accept && bus.i_cmd == CMD_SZ'(CMD_STOP)) ? ST_IDLE : ST_RUN;
            end
            ST_STEP: begin
                pipe_en  = 1'b1;
                pc_en    = !bus.i_halt_D;
                state_nx = bus.i_halt_D ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                pipe_en  = 1'b1;
                state_nx = drain_last ? ST_HALTED : ST_DRAIN;
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_IDLE;
        endcase
    end

    cycle_counter #(.W(CNT_SZ)) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (pipe_en),
        .o_count (count)
    );

    assign bus.o_cmd_ready   = ready;
    assign bus.o_pipe_en     = pipe_en;
    assign bus.o_pc_en       = pc_en;
    assign bus.o_halted      = state == ST_HALTED;
    assign bus.o_cycle_count = count;
    assign bus.o_state       = state;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus random stimulus checked every cycle against a behavioural model.
module tb_pipeline_ctrl;
    logic i_clk = 1'b0;
    logic i_reset;
    int   tests = 0;
    int   fails = 0;
    int   pipe_hi = 0;

    always #5 i_clk = ~i_clk;

    pipeline_ctrl_if #(.CNT_SZ(32), .CMD_SZ(2)) bus ();
    pipeline_ctrl_if #(.CNT_SZ(3),  .CMD_SZ(2)) bus3 ();

    assign bus3.i_cmd       = bus.i_cmd;
    assign bus3.i_cmd_valid = bus.i_cmd_valid;
    assign bus3.i_halt_D    = bus.i_halt_D;

    pipeline_ctrl #(.CNT_SZ(32), .DRAIN_CYC(3), .CMD_SZ(2)) dut (
        .i_clk (i_clk), .i_reset (i_reset), .bus (bus.slave));
    pipeline_ctrl #(.CNT_SZ(3), .DRAIN_CYC(3), .CMD_SZ(2)) dut3 (
        .i_clk (i_clk), .i_reset (i_reset), .bus (bus3.slave));

    // model: mode 0 idle, 1 run, 2 step, 3 drain, 4 halted; left = drain cycles still owed
    int          ms = 0;
    int          mleft = 0;
    logic [31:0] mcnt = '0;

    always @(posedge i_clk) begin : model
        int ns, nl;
        bit acc, busy;
        ns   = ms;
        nl   = mleft;
        busy = ms >= 1 && ms <= 3;
        acc  = bus.i_cmd_valid && (ms == 0 || ms == 1 || ms == 4);
        if (!i_reset) begin
            ms <= 0; mleft <= 0; mcnt <= '0;
        end else begin
            if (ms == 0 && acc) ns = (bus.i_cmd == 2'd1) ? 1 : (bus.i_cmd == 2'd2) ? 2 : 0;
            if ((ms == 1 || ms == 2) && bus.i_halt_D) begin ns = 3; nl = 3; end
            else if (ms == 1 && acc && bus.i_cmd == 2'd3) ns = 0;
            else if (ms == 2) ns = 0;
            if (ms == 3) begin nl = mleft - 1; ns = (nl == 0) ? 4 : 3; end
            ms    <= ns;
            mleft <= nl;
            mcnt  <= busy ? mcnt + 32'd1 : mcnt;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        chk("pipe_en",   bus.o_pipe_en,   (ms >= 1 && ms <= 3));
        chk("pc_en",     bus.o_pc_en,     (ms == 1 || ms == 2) && !bus.i_halt_D);
        chk("cmd_ready", bus.o_cmd_ready, (ms == 0 || ms == 1 || ms == 4));
        chk("halted",    bus.o_halted,    ms == 4);
        chk("state",     bus.o_state,     ms[2:0]);
        chk("count",     bus.o_cycle_count, mcnt);
        chk("count3",    bus3.o_cycle_count, mcnt[2:0]);
        if (bus.o_pipe_en) pipe_hi++;
    end

    task automatic drive(input logic r, input logic v, input logic [1:0] c, input logic h);
        i_reset = r; bus.i_cmd_valid = v; bus.i_cmd = c; bus.i_halt_D = h;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic do_reset();
        drive(0, 0, 2'd0, 0); tick(1); drive(1, 0, 2'd0, 0);
    endtask

    initial begin
        drive(0, 1, 2'd1, 1);
        tick(2);
        chk("rst_state", bus.o_state, 0);
        chk("rst_pipe",  bus.o_pipe_en, 0);
        chk("rst_ready", bus.o_cmd_ready, 1);
        chk("rst_count", bus.o_cycle_count, 0);
        chk("rst_halt",  bus.o_halted, 0);
        // three single steps
        drive(1, 0, 2'd0, 0); tick(1);
        pipe_hi = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'd2, 0); tick(1);
            chk("step_state", bus.o_state, 2);
            drive(1, 0, 2'd0, 0); tick(1);
            chk("step_back", bus.o_state, 0);
            drive(1, 1, 2'd0, 0); tick(1);
        end
        drive(1, 0, 2'd0, 0); tick(1);
        chk("step_count", bus.o_cycle_count, 3);
        chk("step_pulses", pipe_hi, 3);
        // run then stop
        do_reset();
        drive(1, 1, 2'd1, 0); tick(1);
        drive(1, 0, 2'd0, 0); tick(9);
        drive(1, 1, 2'd3, 0); tick(1);
        chk("stop_count", bus.o_cycle_count, 10);
        chk("stop_state", bus.o_state, 0);
        chk("stop_pipe",  bus.o_pipe_en, 0);
        // run then halt in cycle 5
        do_reset();
        drive(1, 1, 2'd1, 0); tick(1);
        drive(1, 0, 2'd0, 0); tick(4);
        drive(1, 0, 2'd0, 1); #1;
        chk("halt_pc", bus.o_pc_en, 0);
        tick(1);
        drive(1, 0, 2'd0, 0);
        chk("drain1", bus.o_state, 3);
        tick(1); chk("drain2", bus.o_state, 3);
        tick(1); chk("drain3", bus.o_state, 3);
        tick(1);
        chk("halted_state", bus.o_state, 4);
        chk("halted_flag",  bus.o_halted, 1);
        chk("halted_count", bus.o_cycle_count, 8);
        chk("halted_pipe",  bus.o_pipe_en, 0);
        // commands in HALTED are consumed and ignored
        drive(1, 1, 2'd1, 0); #1;
        chk("hlt_ready_run", bus.o_cmd_ready, 1);
        tick(1);
        drive(1, 1, 2'd2, 0); #1;
        chk("hlt_ready_step", bus.o_cmd_ready, 1);
        tick(1);
        chk("hlt_stay", bus.o_state, 4);
        chk("hlt_count", bus.o_cycle_count, 8);
        // halt and stop together
        do_reset();
        drive(1, 1, 2'd1, 0); tick(1);
        drive(1, 0, 2'd0, 0); tick(2);
        drive(1, 1, 2'd3, 1); tick(1);
        drive(1, 0, 2'd0, 0);
        chk("hs_drain", bus.o_state, 3);
        tick(2); chk("hs_drain3", bus.o_state, 3);
        tick(1); chk("hs_halted", bus.o_state, 4);
        // reset in second drain cycle
        do_reset();
        drive(1, 1, 2'd1, 0); tick(1);
        drive(1, 0, 2'd0, 1); tick(1);
        drive(1, 0, 2'd0, 0); tick(1);
        chk("rd_in_drain", bus.o_state, 3);
        drive(0, 1, 2'd1, 1); tick(1);
        chk("rd_state", bus.o_state, 0);
        chk("rd_count", bus.o_cycle_count, 0);
        chk("rd_halted", bus.o_halted, 0);
        drive(1, 1, 2'd1, 0); tick(1);
        chk("rd_run", bus.o_state, 1);
        drive(1, 0, 2'd0, 0); tick(2);
        drive(1, 1, 2'd3, 0); tick(1);
        chk("rd_stop_count", bus.o_cycle_count, 3);
        chk("rd_stop_state", bus.o_state, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            tick(1);
        end
        drive(1, 0, 2'd0, 0); tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter CNT_SZ, default 32, width of the executed-cycle counter.
REQ-002 Parameter DRAIN_CYC, default 3, cycles needed to retire instructions in EX/MEM/WB after a HALT reaches ID.
REQ-003 Parameter CMD_SZ, default 2, command code width.
REQ-004 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-low.
REQ-006 i_cmd  input  CMD_SZ  debug command: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
REQ-007 i_cmd_valid  input  1  i_cmd is valid this cycle.
REQ-008 o_cmd_ready  output  1  controller can accept a command; a command is consumed when valid and ready are both high.
REQ-009 i_halt_D  input  1  HALT instruction is present in the ID stage.
REQ-010 o_pipe_en  output  1  enable for every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the register file write.
REQ-011 o_pc_en  output  1  PC update enable.
REQ-012 o_halted  output  1  program finished and pipeline drained.
REQ-013 o_cycle_count  output  CNT_SZ  number of cycles with o_pipe_en high since reset.
REQ-014 o_state  output  3  current FSM state code, for the debug unit.

Function
REQ-015 FSM states, with codes: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
REQ-016 IDLE: pipe_en=0, pc_en=0, cmd_ready=1. Accepted RUN goes to RUN; STEP goes to STEP; NOP and STOP stay in IDLE.
REQ-017 RUN: pipe_en=1, cmd_ready=1, pc_en = NOT i_halt_D (Mealy).
- i_halt_D=1 goes to DRAIN.
- Otherwise, an accepted STOP goes to IDLE.
- RUN, STEP and NOP are consumed with no effect.
REQ-018 RUN, simultaneous i_halt_D=1 and accepted STOP: halt wins, next state DRAIN, STOP consumed.
REQ-019 STEP: lasts exactly one cycle; pipe_en=1, pc_en = NOT i_halt_D, cmd_ready=0. Next state is DRAIN if i_halt_D=1, else IDLE.
REQ-020 DRAIN: pipe_en=1, pc_en=0, cmd_ready=0.
- A drain counter loads 0 on entry and increments each cycle.
- After exactly DRAIN_CYC cycles in DRAIN, go to HALTED.
REQ-021 HALTED: pipe_en=0, pc_en=0, o_halted=1, cmd_ready=1. Commands are consumed and ignored; the only exit is reset.
REQ-022 Latency: a command accepted at edge k changes o_state at edge k; the new pipe_en value is visible in the cycle following edge k.
REQ-023 o_cycle_count increments by 1 on each edge where o_pipe_en=1, and wraps to 0 after its maximum value.
REQ-024 o_halted=1 only in HALTED.
REQ-025 i_cmd values are ignored whenever i_cmd_valid=0.

Reset
REQ-026 While i_reset=0 at a rising edge, the following are applied at that edge, including mid-RUN or mid-DRAIN:
- state becomes IDLE;
- drain counter becomes 0;
- o_cycle_count becomes 0.
REQ-027 Output values in reset and after reset: o_pipe_en=0, o_pc_en=0, o_halted=0, o_cmd_ready=1, o_state=0, o_cycle_count=0.
REQ-028 Inputs are ignored during reset; there is no residual pending command after reset.

Structure
REQ-029 State codes, command codes and DRAIN_CYC default belong in shared package pipeline_pkg.
REQ-030 The cycle counter is a sub-module, cycle_counter (enable, synchronous active-low reset, wrap).
REQ-031 The FSM uses a registered state and combinational next-state/output logic; o_pc_en is the only Mealy output.

Verification
REQ-032 Reset, then STEP accepted three times (NOP gaps) -> o_pipe_en high exactly 3 single cycles, o_cycle_count=3, o_state returns to 0 each time.
REQ-033 RUN accepted, STOP accepted 10 cycles later -> o_cycle_count=10, o_state=0, o_pipe_en=0.
REQ-034 RUN, then i_halt_D=1 on cycle 5 -> o_pc_en=0 that cycle, DRAIN lasts 3 cycles, then o_halted=1, o_cycle_count=8, pipe_en=0.
REQ-035 RUN with i_halt_D=1 and STOP in the same cycle -> o_state=3 (DRAIN) next, then HALTED after 3 cycles.
REQ-036 Reset asserted in the second DRAIN cycle -> next cycle o_state=0, o_cycle_count=0, o_halted=0; subsequent RUN works normally.
REQ-037 In HALTED, issue RUN and STEP -> both consumed (ready=1), o_state stays 4, o_cycle_count unchanged.
